// File: rtl/reg_file.sv
// reg_file -- 32 x 32-bit MIPS general-purpose register file.
//
// Two combinational read ports (rs/rt), one synchronous write port fed by the
// write-back muxes, a combinational debug peek port and a counter of committed
// architectural writes. Register $0 reads as zero and ignores writes.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (clears array and counter)
//   reg_write  in   write enable from the control unit
//   wr_addr    in   destination register (ADDR_W)
//   wr_data    in   write-back value (DATA_W)
//   rd_addr1   in   source register rs
//   rd_addr2   in   source register rt
//   rd_data1   out  value of rs
//   rd_data2   out  value of rt
//   dbg_addr   in   debug peek address
//   dbg_data   out  value at dbg_addr
//   wr_count   out  committed write count, wraps modulo 2**CNT_W
//
// Build option:
//   REGFILE_BYPASS_EN  when defined, a read of the register being written in
//                      the same cycle returns wr_data (write-through
//                      forwarding) on both read ports and the debug port.
module reg_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [CNT_W-1:0]  wr_count_q;
  logic [CNT_W-1:0]  wr_count_d;
  logic              wr_en;

  // Writes to $0 are architecturally discarded and never counted.
  assign wr_en = reg_write && (wr_addr != '0);

  always_comb begin
    wr_count_d = wr_count_q;
    if (wr_en) begin
      wr_count_d = wr_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
      wr_count_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_addr] <= wr_data;
      end
      wr_count_q <= wr_count_d;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    if (a != '0) begin
      v = mem_q[a];
`ifdef REGFILE_BYPASS_EN
      // Forwarding is gated by rst_n so reads stay zero throughout reset.
      if (rst_n && wr_en && (a == wr_addr)) begin
        v = wr_data;
      end
`endif
    end
    return v;
  endfunction

  always_comb begin
    rd_data1 = read_port(rd_addr1);
    rd_data2 = read_port(rd_addr2);
    dbg_data = read_port(dbg_addr);
  end

  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        reg_write = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [4:0]  rd_addr1 = '0;
  logic [4:0]  rd_addr2 = '0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] rd_data1, rd_data2, dbg_data, wr_count;
  logic [31:0] s_rd_data1, s_rd_data2, s_dbg_data;
  logic [3:0]  s_wr_count;

  always #5 clk = ~clk;

  reg_file #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .wr_count(wr_count)
  );

  // Narrow-counter instance sharing all inputs, used for the wrap check.
  reg_file #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(s_rd_data1), .rd_data2(s_rd_data2), .dbg_addr(dbg_addr),
    .dbg_data(s_dbg_data), .wr_count(s_wr_count)
  );

  typedef struct {
    string       name;
    int          sel;   // 0 rd_data1, 1 rd_data2, 2 dbg_data, 3 wr_count, 4 narrow wr_count
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic expect_out(input string nm, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = nm;
    e.sel  = sel;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    reg_write = 1'b1;
    wr_addr   = a;
    wr_data   = d;
    next_cycle();
    reg_write = 1'b0;
  endtask

  // Monitor: outputs are combinational and stable by the falling edge,
  // so every queued expectation is resolved there.
  always @(negedge clk) begin
    logic [31:0] act;
    exp_t e;
    if (rst_n === 1'b1 && $isunknown({reg_write, wr_addr})) begin
      failures++;
      $display("FAIL xcheck: reg_write/wr_addr unknown act=%b/%b req=known", reg_write, wr_addr);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       act = rd_data1;
        1:       act = rd_data2;
        2:       act = dbg_data;
        3:       act = wr_count;
        default: act = {28'd0, s_wr_count};
      endcase
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: act=%h req=%h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: act=running req=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: mid-cycle reset pulse, then every address reads zero
    #7 rst_n = 1'b0;
    #5 rst_n = 1'b1;
    next_cycle();
    for (int a = 0; a < 32; a++) begin
      rd_addr1 = 5'(a);
      rd_addr2 = 5'(31 - a);
      dbg_addr = 5'(a);
      expect_out("reset_rd1", 0, 32'h0);
      expect_out("reset_rd2", 1, 32'h0);
      expect_out("reset_dbg", 2, 32'h0);
      next_cycle();
    end
    expect_out("reset_cnt", 3, 32'd0);
    next_cycle();

    // 2: basic write/read
    wr(5'd8, 32'hDEADBEEF);
    wr(5'd31, 32'h12345678);
    rd_addr1 = 5'd8; rd_addr2 = 5'd31; dbg_addr = 5'd31;
    expect_out("basic_rd1", 0, 32'hDEADBEEF);
    expect_out("basic_rd2", 1, 32'h12345678);
    expect_out("basic_dbg", 2, 32'h12345678);
    expect_out("basic_cnt", 3, 32'd2);
    next_cycle();
    // simultaneous reads of one register
    rd_addr1 = 5'd8; rd_addr2 = 5'd8; dbg_addr = 5'd8;
    expect_out("same_rd1", 0, 32'hDEADBEEF);
    expect_out("same_rd2", 1, 32'hDEADBEEF);
    expect_out("same_dbg", 2, 32'hDEADBEEF);
    next_cycle();

    // 3: $zero protection and write-enable low
    reg_write = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    rd_addr1 = 5'd0; dbg_addr = 5'd0;
    expect_out("zero_same_rd1", 0, 32'h0);
    expect_out("zero_same_dbg", 2, 32'h0);
    next_cycle();
    reg_write = 1'b0;
    expect_out("zero_rd1", 0, 32'h0);
    expect_out("zero_cnt", 3, 32'd2);
    next_cycle();
    wr(5'd5, 32'h00000055);
    reg_write = 1'b0; wr_addr = 5'd5; wr_data = 32'h00000BAD;
    next_cycle();
    rd_addr2 = 5'd5;
    expect_out("we0_rd2", 1, 32'h00000055);
    expect_out("we0_cnt", 3, 32'd3);
    next_cycle();

    // 4: same-cycle read of the register being written
    wr(5'd9, 32'h00000001);
    reg_write = 1'b1; wr_addr = 5'd9; wr_data = 32'hAAAA5555;
    rd_addr1 = 5'd9; dbg_addr = 5'd9;
`ifdef REGFILE_BYPASS_EN
    expect_out("samecyc_rd1", 0, 32'hAAAA5555);
    expect_out("samecyc_dbg", 2, 32'hAAAA5555);
`else
    expect_out("samecyc_rd1", 0, 32'h00000001);
    expect_out("samecyc_dbg", 2, 32'h00000001);
`endif
    next_cycle();
    reg_write = 1'b0;
    expect_out("nextcyc_rd1", 0, 32'hAAAA5555);
    expect_out("nextcyc_cnt", 3, 32'd5);
    next_cycle();

    // 5: reset mid-operation with a write pending
    wr(5'd1, 32'h11); wr(5'd2, 32'h22); wr(5'd3, 32'h33); wr(5'd4, 32'h44);
    rd_addr1 = 5'd2;
    expect_out("prefill_rd1", 0, 32'h22);
    expect_out("prefill_cnt", 3, 32'd9);
    next_cycle();
    reg_write = 1'b1; wr_addr = 5'd6; wr_data = 32'h66;
    #2 rst_n = 1'b0;
    rd_addr1 = 5'd1; rd_addr2 = 5'd3; dbg_addr = 5'd6;
    expect_out("midrst_rd1", 0, 32'h0);
    expect_out("midrst_rd2", 1, 32'h0);
    expect_out("midrst_dbg", 2, 32'h0);
    expect_out("midrst_cnt", 3, 32'd0);
    next_cycle();
    rd_addr1 = 5'd4;
    expect_out("inrst_rd1", 0, 32'h0);
    expect_out("inrst_dbg", 2, 32'h0);
    expect_out("inrst_cnt", 3, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    reg_write = 1'b0;
    rd_addr1 = 5'd6; rd_addr2 = 5'd1;
    expect_out("postrst_rd1", 0, 32'h66);
    expect_out("postrst_rd2", 1, 32'h0);
    expect_out("postrst_cnt", 3, 32'd1);
    next_cycle();

    // 6: counter wrap on the 4-bit instance
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    next_cycle();
    for (int i = 0; i < 16; i++) begin
      wr(5'd3, 32'h300 + 32'(i));
    end
    expect_out("wrap16_c4", 4, 32'd0);
    expect_out("wrap16_cnt", 3, 32'd16);
    next_cycle();
    wr(5'd3, 32'h310);
    rd_addr1 = 5'd3;
    expect_out("wrap17_c4", 4, 32'd1);
    expect_out("wrap17_cnt", 3, 32'd17);
    expect_out("wrap17_rd1", 0, 32'h310);
    next_cycle();

    next_cycle();
    next_cycle();
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: act=%0d req=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
